// File: rtl/prim_fifo_sync_wm.sv
// Synchronous valid/ready FIFO with a registered occupancy count, runtime
// almost-full/almost-empty watermarks and a high-water-mark monitor.
module prim_fifo_sync_wm #(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 4,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    input  logic [DepthW-1:0] af_th_i,
    input  logic [DepthW-1:0] ae_th_i,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [DepthW-1:0] max_depth_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW-1:0]   PtrLast  = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);

    logic [Width-1:0]  storage [Depth];
    logic [PtrW-1:0]   wptr, rptr;
    logic [DepthW-1:0] cnt, cnt_next, maxd;
    logic              push, pop, pass_through, wr_en, rd_en;
    logic              cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Handshake: a transfer on either side completes only when valid and
    // ready are both high in the same cycle; clr_i blocks both sides.
    assign wready_o = ~clr_i & (cnt < DepthMax);
    assign rvalid_o = ~clr_i & (~cnt_zero | (Pass & wvalid_i));

    assign push = wvalid_i & wready_o;
    assign pop  = rvalid_o & rready_i;

    // An empty FIFO that pushes and pops together hands the word straight
    // across; storage, pointers and count are left alone.
    assign pass_through = Pass & cnt_zero & push & pop;
    assign wr_en        = push & ~pass_through;
    assign rd_en        = pop & ~pass_through;

    always_comb begin
        cnt_next = cnt;
        if (clr_i) begin
            cnt_next = '0;
        end else if (wr_en && !rd_en) begin
            cnt_next = cnt + DepthW'(1);
        end else if (rd_en && !wr_en) begin
            cnt_next = cnt - DepthW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            maxd <= '0;
        end else if (clr_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            maxd <= '0;
        end else begin
            if (wr_en) begin
                wptr <= (wptr == PtrLast) ? '0 : wptr + PtrW'(1);
            end
            if (rd_en) begin
                rptr <= (rptr == PtrLast) ? '0 : rptr + PtrW'(1);
            end
            cnt <= cnt_next;
            // Compared against the next count so the monitor never lags depth_o.
            if (cnt_next > maxd) begin
                maxd <= cnt_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            storage[wptr] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = storage[rptr];
        if (OutputZeroIfEmpty && !rvalid_o) begin
            rdata_o = '0;
        end else if (cnt_zero && Pass && wvalid_i) begin
            rdata_o = wdata_i;
        end
    end

    assign depth_o        = cnt;
    assign full_o         = (cnt == DepthMax);
    assign empty_o        = cnt_zero;
    assign almost_full_o  = (cnt >= af_th_i);
    assign almost_empty_o = (cnt <= ae_th_i);
    assign max_depth_o    = maxd;

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Bench for prim_fifo_sync_wm: instance A (Depth 3, no passthrough) and
// instance B (Depth 4, passthrough) checked with vectors, sequences and a model.
module tb_prim_fifo_sync_wm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    // Instance A: Width 8, Depth 3, Pass 0
    logic       a_clr = 1'b0, a_wv = 1'b0, a_rr = 1'b0;
    logic [7:0] a_wd = 8'h00;
    logic [1:0] a_af = 2'd2, a_ae = 2'd1;
    logic       a_wr, a_rv, a_full, a_empty, a_afl, a_aem;
    logic [7:0] a_rd;
    logic [1:0] a_dep, a_mx;

    prim_fifo_sync_wm #(.Width(8), .Depth(3), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr),
        .wvalid_i(a_wv), .wready_o(a_wr), .wdata_i(a_wd),
        .rvalid_o(a_rv), .rready_i(a_rr), .rdata_o(a_rd),
        .af_th_i(a_af), .ae_th_i(a_ae), .depth_o(a_dep),
        .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_afl),
        .almost_empty_o(a_aem), .max_depth_o(a_mx)
    );

    // Instance B: Width 8, Depth 4, Pass 1
    logic       b_clr = 1'b0, b_wv = 1'b0, b_rr = 1'b0;
    logic [7:0] b_wd = 8'h00;
    logic [2:0] b_af = 3'd3, b_ae = 3'd1;
    logic       b_wr, b_rv, b_full, b_empty, b_afl, b_aem;
    logic [7:0] b_rd;
    logic [2:0] b_dep, b_mx;

    prim_fifo_sync_wm #(.Width(8), .Depth(4), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr),
        .wvalid_i(b_wv), .wready_o(b_wr), .wdata_i(b_wd),
        .rvalid_o(b_rv), .rready_i(b_rr), .rdata_o(b_rd),
        .af_th_i(b_af), .ae_th_i(b_ae), .depth_o(b_dep),
        .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_afl),
        .almost_empty_o(b_aem), .max_depth_o(b_mx)
    );

    typedef struct {
        logic [2:0] ctl;   // {clr, wvalid, rready}
        logic [7:0] wd;
        logic [1:0] hs;    // {wready, rvalid}
        logic [7:0] rd;
        logic [1:0] dep;
        logic [3:0] fl;    // {full, empty, almost_full, almost_empty}
        logic [1:0] mx;
    } vec_t;

    vec_t vecs [13];
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic b_step(input logic clr, input logic wv, input logic [7:0] wd, input logic rr);
        @(negedge clk);
        b_clr = clr;
        b_wv  = wv;
        b_wd  = wd;
        b_rr  = rr;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         sz, mmax;
        logic       e_wr, e_rv, push, pop;
        logic [7:0] e_rd;

        // Fill, full-while-writing, wrap, drain, then clear of the monitor
        vecs[0]  = '{3'b000, 8'h00, 2'b10, 8'h00, 2'd0, 4'b0101, 2'd0};
        vecs[1]  = '{3'b010, 8'h11, 2'b10, 8'h00, 2'd0, 4'b0101, 2'd0};
        vecs[2]  = '{3'b010, 8'h22, 2'b11, 8'h11, 2'd1, 4'b0001, 2'd1};
        vecs[3]  = '{3'b010, 8'h33, 2'b11, 8'h11, 2'd2, 4'b0010, 2'd2};
        vecs[4]  = '{3'b010, 8'h99, 2'b01, 8'h11, 2'd3, 4'b1010, 2'd3};
        vecs[5]  = '{3'b001, 8'h00, 2'b01, 8'h11, 2'd3, 4'b1010, 2'd3};
        vecs[6]  = '{3'b010, 8'h44, 2'b11, 8'h22, 2'd2, 4'b0010, 2'd3};
        vecs[7]  = '{3'b001, 8'h00, 2'b01, 8'h22, 2'd3, 4'b1010, 2'd3};
        vecs[8]  = '{3'b001, 8'h00, 2'b11, 8'h33, 2'd2, 4'b0010, 2'd3};
        vecs[9]  = '{3'b001, 8'h00, 2'b11, 8'h44, 2'd1, 4'b0001, 2'd3};
        vecs[10] = '{3'b000, 8'h00, 2'b10, 8'h00, 2'd0, 4'b0101, 2'd3};
        vecs[11] = '{3'b110, 8'h55, 2'b00, 8'h00, 2'd0, 4'b0101, 2'd3};
        vecs[12] = '{3'b000, 8'h00, 2'b10, 8'h00, 2'd0, 4'b0101, 2'd0};

        // Reset: hold for two edges, check state while rst_n is still low
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_wv = 1'b1;
        b_wv = 1'b1;
        b_wd = 8'h5A;
        #1;
        chk("rst_a_wready", 32'(a_wr), 32'd1);
        chk("rst_a_rvalid", 32'(a_rv), 32'd0);
        chk("rst_a_depth", 32'(a_dep), 32'd0);
        chk("rst_b_rvalid", 32'(b_rv), 32'd1);
        chk("rst_b_rdata", 32'(b_rd), 32'h5A);
        chk("rst_b_flags", 32'({b_full, b_empty}), 32'b01);
        chk("rst_b_maxd", 32'(b_mx), 32'd0);
        @(negedge clk);
        a_wv  = 1'b0;
        b_wv  = 1'b0;
        rst_n = 1'b1;

        // Instance A vector table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            {a_clr, a_wv, a_rr} = vecs[i].ctl;
            a_wd = vecs[i].wd;
            #1;
            chk($sformatf("a_hs[%0d]", i), 32'({a_wr, a_rv}), 32'(vecs[i].hs));
            chk($sformatf("a_rdata[%0d]", i), 32'(a_rd), 32'(vecs[i].rd));
            chk($sformatf("a_depth[%0d]", i), 32'(a_dep), 32'(vecs[i].dep));
            chk($sformatf("a_flags[%0d]", i), 32'({a_full, a_empty, a_afl, a_aem}), 32'(vecs[i].fl));
            chk($sformatf("a_maxd[%0d]", i), 32'(a_mx), 32'(vecs[i].mx));
        end

        // Passthrough on an empty FIFO
        b_step(1'b0, 1'b1, 8'hA5, 1'b1);
        chk("pt_rvalid", 32'(b_rv), 32'd1);
        chk("pt_rdata", 32'(b_rd), 32'hA5);
        chk("pt_wready", 32'(b_wr), 32'd1);
        b_step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pt_depth", 32'(b_dep), 32'd0);
        chk("pt_maxd", 32'(b_mx), 32'd0);
        chk("pt_rdata_zero", 32'(b_rd), 32'd0);

        // Watermarks with af=3, ae=1, including a same-cycle threshold change
        b_af = 3'd3;
        b_ae = 3'd1;
        for (int k = 0; k < 3; k++) begin
            b_step(1'b0, 1'b1, 8'(8'h10 + k), 1'b0);
            chk($sformatf("wm_aem[%0d]", k), 32'(b_aem), 32'(k <= 1));
            chk($sformatf("wm_afl[%0d]", k), 32'(b_afl), 32'd0);
        end
        b_step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("wm_d3_afl", 32'({b_dep, b_afl, b_aem}), 32'({3'd3, 1'b1, 1'b0}));
        b_af = 3'd4;
        #1;
        chk("wm_af4_same_cycle", 32'(b_afl), 32'd0);
        b_step(1'b0, 1'b1, 8'h13, 1'b0);
        chk("wm_push4_afl", 32'(b_afl), 32'd0);
        b_step(1'b0, 1'b1, 8'hEE, 1'b0);
        chk("wm_full", 32'({b_dep, b_full, b_wr, b_afl}), 32'({3'd4, 1'b1, 1'b0, 1'b1}));
        b_af = 3'd0;
        b_ae = 3'd4;
        #1;
        chk("wm_th_extremes", 32'({b_afl, b_aem}), 32'b11);
        b_af = 3'd3;
        b_ae = 3'd1;
        for (int k = 0; k < 4; k++) begin
            b_step(1'b0, 1'b0, 8'h00, 1'b1);
            chk($sformatf("wm_drain[%0d]", k), 32'(b_rd), 32'(8'h10 + k));
        end
        b_step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("wm_maxd", 32'({b_dep, b_mx}), 32'({3'd0, 3'd4}));

        // Simultaneous push and pop at depth 2
        b_step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("cl_hs", 32'({b_wr, b_rv}), 32'b00);
        b_step(1'b0, 1'b1, 8'h20, 1'b0);
        b_step(1'b0, 1'b1, 8'h21, 1'b0);
        for (int j = 0; j < 5; j++) begin
            b_step(1'b0, 1'b1, 8'(8'h22 + j), 1'b1);
            chk($sformatf("pp_depth[%0d]", j), 32'(b_dep), 32'd2);
            chk($sformatf("pp_rdata[%0d]", j), 32'(b_rd), 32'(8'h20 + j));
        end
        b_step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pp_end", 32'({b_dep, b_mx, b_rd}), 32'({3'd2, 3'd2, 8'h25}));

        // Clear mid-stream at depth 3 with both sides active
        b_step(1'b0, 1'b1, 8'h30, 1'b0);
        b_step(1'b1, 1'b1, 8'h31, 1'b1);
        chk("clr_hs", 32'({b_wr, b_rv}), 32'b00);
        chk("clr_depth_before", 32'(b_dep), 32'd3);
        b_step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("clr_after", 32'({b_dep, b_mx, b_empty, b_rv}), 32'({3'd0, 3'd0, 1'b1, 1'b0}));
        chk("clr_rdata", 32'(b_rd), 32'd0);

        // Randomized traffic against a queue model
        sz   = 0;
        mmax = 0;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            b_clr = ($urandom_range(0, 24) == 0);
            b_wv  = 1'($urandom_range(0, 1));
            b_rr  = 1'($urandom_range(0, 1));
            b_wd  = 8'($urandom);
            b_af  = 3'($urandom_range(0, 5));
            b_ae  = 3'($urandom_range(0, 7));
            #1;
            sz   = exp_q.size();
            e_wr = !b_clr && (sz < 4);
            e_rv = !b_clr && (sz != 0 || b_wv);
            e_rd = !e_rv ? 8'h00 : (sz != 0 ? exp_q[0] : b_wd);
            chk("rnd_wready", 32'(b_wr), 32'(e_wr));
            chk("rnd_rvalid", 32'(b_rv), 32'(e_rv));
            chk("rnd_rdata", 32'(b_rd), 32'(e_rd));
            chk("rnd_depth", 32'(b_dep), 32'(sz));
            chk("rnd_flags", 32'({b_full, b_empty, b_afl, b_aem}),
                32'({sz == 4, sz == 0, sz >= int'(b_af), sz <= int'(b_ae)}));
            chk("rnd_maxd", 32'(b_mx), 32'(mmax));
            push = b_wv && e_wr;
            pop  = e_rv && b_rr;
            if (b_clr) begin
                exp_q.delete();
                mmax = 0;
            end else if (!(sz == 0 && push && pop)) begin
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(b_wd);
            end
            if (exp_q.size() > mmax) mmax = exp_q.size();
        end
        b_af = 3'd3;
        b_ae = 3'd1;

        // Synchronous reset at depth 2
        b_step(1'b1, 1'b0, 8'h00, 1'b0);
        b_step(1'b0, 1'b1, 8'h40, 1'b0);
        b_step(1'b0, 1'b1, 8'h41, 1'b0);
        b_step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("sr_depth_before", 32'(b_dep), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("sr_no_edge_yet", 32'({b_dep, b_empty}), 32'({3'd2, 1'b0}));
        @(negedge clk);
        #1;
        chk("sr_after_edge", 32'({b_dep, b_empty, b_mx, b_wr}), 32'({3'd0, 1'b1, 3'd0, 1'b1}));
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prim_fifo_sync_wm.md
Name: prim_fifo_sync_wm

Overview:
Parametrised synchronous valid/ready FIFO that extends the team's basic sync FIFO. Adds a registered occupancy counter, runtime-programmable almost-full and almost-empty watermarks, and a high-water-mark monitor. Clear gating is defined, and non-power-of-two depths are supported. It sits between producer and consumer blocks, for example TL-UL adapters and crypto-core data paths, where software needs flow-control thresholds and occupancy statistics.

Parameters:
Width, 16, data width in bits (>=1)
Depth, 4, number of storage entries (>=2; any integer, no power-of-two requirement)
Pass, 1, 1 lets an empty FIFO forward wdata_i straight to rdata_o in the same cycle
OutputZeroIfEmpty, 1, 1 forces rdata_o to 0 whenever rvalid_o=0
DepthW, $clog2(Depth+1), derived width of the occupancy fields; not overridable

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  reset, synchronous, active-low
clr_i  in  1  synchronous flush
wvalid_i  in  1  write valid
wready_o  out  1  write ready
wdata_i  in  Width  write data
rvalid_o  out  1  read valid
rready_i  in  1  read ready
rdata_o  out  Width  read data
af_th_i  in  DepthW  almost-full threshold
ae_th_i  in  DepthW  almost-empty threshold
depth_o  out  DepthW  current occupancy (registered)
full_o  out  1  depth_o==Depth
empty_o  out  1  depth_o==0
almost_full_o  out  1  depth_o>=af_th_i
almost_empty_o  out  1  depth_o<=ae_th_i
max_depth_o  out  DepthW  highest depth_o reached since reset or clear (registered)

Behaviour:
- State: wptr, rptr (0..Depth-1), cnt (0..Depth), maxd, storage[Depth]. There are no data flops on the output path.
- Reset: when rst_ni=0 at a clock edge, wptr, rptr, cnt and maxd all become 0. Storage is not reset.
  - Outputs after reset: wready_o=1, depth_o=0, empty_o=1, full_o=0, max_depth_o=0.
  - rvalid_o after reset equals Pass&wvalid_i.
  - Reset overrides clr_i and any handshake in the same cycle. Data in flight is discarded.
- Clear: with clr_i=1, wready_o=0 and rvalid_o=0 combinationally. No handshake completes. Next cycle wptr, rptr, cnt and maxd are all 0.
- Ready and valid:
  - wready_o = ~clr_i & (cnt<Depth).
  - rvalid_o = ~clr_i & ((cnt!=0) | (Pass & wvalid_i)).
- push = wvalid_i&wready_o. pop = rvalid_o&rready_i.
- rdata_o:
  - When cnt!=0: storage[rptr].
  - When cnt==0 and Pass=1 and wvalid_i=1: wdata_i.
  - Otherwise, rdata_o is 0 if OutputZeroIfEmpty, else storage[rptr].
- Passthrough (Pass=1, cnt==0, push and pop in the same cycle): the data bypasses storage. wptr, rptr and cnt are unchanged.
  - If cnt==0, push=1 and pop=0, the entry is written normally.
- Storage and pointer update:
  - Write: on push (except passthrough), storage[wptr]<=wdata_i and wptr advances.
  - Read: on pop (except passthrough), rptr advances.
  - Wrap-around: a pointer equal to Depth-1 advances to 0.
- cnt next value:
  - cnt+1 on push-only.
  - cnt-1 on pop-only.
  - Unchanged on push+pop, including the passthrough case.
  - Push and pop together while full cannot happen, since wready_o=0 when full. A pop while full frees space in the next cycle, not the same cycle.
- Occupancy outputs are decoded combinationally from the registered counter (cnt); the thresholds are not registered:
  - depth_o=cnt.
  - full_o, empty_o, almost_full_o and almost_empty_o decode from cnt.
  - af_th_i=0 gives almost_full_o=1 always. ae_th_i>=Depth gives almost_empty_o=1 always. Threshold changes take effect in the same cycle.
- max_depth_o: maxd<=cnt_next when cnt_next>maxd, so max_depth_o tracks occupancy with no lag relative to depth_o. It saturates at Depth and only clears via reset or clr_i.
- Width rule: all counter arithmetic is done at DepthW bits and must not overflow, since cnt never exceeds Depth.

Test Plan:
1. Fill and wrap (Width=8, Depth=3, Pass=0): push 0x11,0x22,0x33 → full_o=1, wready_o=0, depth_o=3. Pop one → next cycle depth_o=2. Push 0x44 (wptr wraps to 0). Drain → order 0x22,0x33,0x44; max_depth_o=3.
2. Passthrough (Pass=1, empty): wvalid_i=1 with 0xA5, rready_i=1 → rvalid_o=1, rdata_o=0xA5 in the same cycle; depth_o stays 0 and max_depth_o stays 0.
3. Watermarks (Depth=4, af_th_i=3, ae_th_i=1): push 4 entries → almost_empty_o deasserts at depth 2, almost_full_o asserts at depth 3. Change af_th_i to 4 at depth 3 → almost_full_o=0 in the same cycle.
4. Simultaneous push+pop at depth 2 for 5 cycles → depth_o stays 2, data is FIFO-ordered, max_depth_o=2.
5. Clear mid-stream at depth 3 with wvalid_i=rready_i=1 → wready_o=rvalid_o=0 in that cycle. Next cycle depth_o=0, max_depth_o=0, and rdata_o=0 (OutputZeroIfEmpty=1, wvalid_i=0).
6. Synchronous reset: drop rst_ni for one edge at depth 2 → next cycle depth_o=0, empty_o=1. Also check that asserting rst_ni between edges has no effect until the clock edge (synchronous reset).
